// File: rtl/frame_source_scheduler.sv
// Frame-aligned arbiter that hands the single RGB444 pixel path to one of NUM_SRC
// Avalon-ST sources, switching only on frame boundaries and owning sop/eop framing.
module frame_source_scheduler #(
  parameter int NUM_SRC    = 3,
  parameter int NUM_PIXELS = 320*240,
  parameter int DATA_W     = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_sop,
  input  logic [NUM_SRC-1:0]        src_eop,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [1:0]                sel_req,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                active_sel,
  output logic                      frame_done,
  output logic                      err_len
);
  localparam int            CW   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_PIXELS - 1);
  localparam logic [2:0]    NSRC = 3'(NUM_SRC);

  typedef enum logic [1:0] {IDLE, SYNC, STREAM} state_t;

  state_t            state;
  logic [CW-1:0]     pix_cnt;
  logic [DATA_W-1:0] act_data;
  logic              act_valid, act_sop, act_eop;
  logic [1:0]        sel_clamp;
  logic              first, last, hs, mismatch;

  // Mux by comparison rather than indexing so any NUM_SRC in 2..4 stays in range.
  always_comb begin
    act_data  = '0;
    act_valid = 1'b0;
    act_sop   = 1'b0;
    act_eop   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active_sel == 2'(i)) begin
        act_data  = src_data[i*DATA_W +: DATA_W];
        act_valid = src_valid[i];
        act_sop   = src_sop[i];
        act_eop   = src_eop[i];
      end
    end
  end

  assign sel_clamp = ({1'b0, sel_req} >= NSRC) ? 2'd0 : sel_req;
  assign first     = (pix_cnt == '0);
  assign last      = (pix_cnt == LAST);
  assign out_valid = (state == STREAM) & act_valid;
  assign out_data  = act_data;
  assign out_sop   = out_valid & first;
  assign out_eop   = out_valid & last;
  assign hs        = out_valid & out_ready;
  assign mismatch  = (act_sop != first) | (act_eop != last);

  // Everything not granted is drained so upstream cameras never back up.
  always_comb begin
    src_ready = '1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (state != IDLE && active_sel == 2'(i)) begin
        if (state == SYNC) src_ready[i] = act_valid & ~act_sop;
        else               src_ready[i] = out_ready;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      active_sel <= 2'd0;
      pix_cnt    <= '0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_len    <= 1'b0;
      unique case (state)
        IDLE: begin
          active_sel <= sel_clamp;
          pix_cnt    <= '0;
          state      <= SYNC;
        end
        SYNC: begin
          // The sop beat is left in place; STREAM forwards it as pixel 0.
          if (act_valid & act_sop) state <= STREAM;
        end
        STREAM: begin
          if (hs) begin
            err_len <= mismatch;
            if (last) begin
              pix_cnt    <= '0;
              frame_done <= 1'b1;
              if (sel_clamp != active_sel) begin
                active_sel <= sel_clamp;
                state      <= SYNC;
              end
            end else begin
              pix_cnt <= pix_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_source_scheduler.sv
// Randomized bench for frame_source_scheduler: cycle-level source models feeding a
// frame-level reference model (expected grant, beat index, pulses).
module tb_frame_source_scheduler;
  localparam int NS = 3, NP = 16, DW = 12;

  logic           clk = 1'b0;
  logic           reset;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]  src_valid, src_sop, src_eop, src_ready;
  logic [1:0]     sel_req;
  logic [DW-1:0]  out_data;
  logic           out_sop, out_eop, out_valid, out_ready;
  logic [1:0]     active_sel;
  logic           frame_done, err_len;

  int checks = 0, failures = 0;
  int pos[NS], fid[NS], bad[NS];
  int p_valid = 100, p_rdy = 100;
  int mdl_sel = 0, mdl_k = 0;
  bit mdl_live = 0, mdl_idle = 0, exp_fd = 0, exp_err = 0, fd_seen = 0;
  int cnt_drop1 = 0, cnt_out = 0, out_at_fd = 0, cnt_err = 0;

  always #5 clk = ~clk;

  frame_source_scheduler #(.NUM_SRC(NS), .NUM_PIXELS(NP), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .src_valid(src_valid),
    .src_sop(src_sop), .src_eop(src_eop), .src_ready(src_ready), .sel_req(sel_req),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_valid(out_valid),
    .out_ready(out_ready), .active_sel(active_sel), .frame_done(frame_done),
    .err_len(err_len));

  // Each pixel tags its source, position in the source's frame and frame number.
  function automatic logic [DW-1:0] mk_pix(int s, int p, int f);
    logic [1:0] a; logic [3:0] b; logic [5:0] c;
    a = s[1:0]; b = p[3:0]; c = f[5:0];
    return {a, b, c};
  endfunction

  function automatic int clampf(int s);
    return (s >= NS) ? 0 : s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit hs_src[NS];
    bit ohs, go, sop_f, eop_f;
    int s_req;
    ohs = 0; go = 0; sop_f = 0; eop_f = 0;
    for (int i = 0; i < NS; i++) begin
      src_valid[i] = (int'($urandom_range(99)) < p_valid);
      src_data[i*DW +: DW] = mk_pix(i, pos[i], fid[i]);
      src_sop[i] = (pos[i] == 0);
      src_eop[i] = (pos[i] == NP-1) || (pos[i] == bad[i]);
    end
    out_ready = (int'($urandom_range(99)) < p_rdy);
    #1;
    fd_seen = frame_done;
    if (frame_done) out_at_fd = cnt_out;
    if (err_len) cnt_err++;
    chk("active_sel", active_sel, mdl_sel);
    chk("frame_done", frame_done, exp_fd);
    chk("err_len", err_len, exp_err);
    for (int i = 0; i < NS; i++)
      if (i != mdl_sel) chk("flush_ready", src_ready[i], 1);
    if (mdl_idle) begin
      chk("idle_valid", out_valid, 0);
    end else if (!mdl_live) begin
      chk("sync_valid", out_valid, 0);
      chk("sync_ready", src_ready[mdl_sel], src_valid[mdl_sel] & ~src_sop[mdl_sel]);
      go = src_valid[mdl_sel] & src_sop[mdl_sel];
    end else begin
      chk("out_valid", out_valid, src_valid[mdl_sel]);
      chk("act_ready", src_ready[mdl_sel], out_ready);
      if (src_valid[mdl_sel]) begin
        chk("out_data", out_data, mk_pix(mdl_sel, mdl_k, fid[mdl_sel]));
        chk("out_sop", out_sop, mdl_k == 0);
        chk("out_eop", out_eop, mdl_k == NP-1);
        ohs = out_ready;
        sop_f = src_sop[mdl_sel];
        eop_f = src_eop[mdl_sel];
      end
    end
    for (int i = 0; i < NS; i++) hs_src[i] = src_valid[i] & src_ready[i];
    if (!mdl_live && hs_src[1]) cnt_drop1++;
    if (ohs) cnt_out++;
    s_req = clampf(sel_req);
    @(posedge clk);
    for (int i = 0; i < NS; i++)
      if (hs_src[i]) begin
        if (pos[i] == NP-1) begin pos[i] = 0; fid[i] = (fid[i] + 1) % 64; end
        else pos[i]++;
      end
    exp_fd  = ohs && (mdl_k == NP-1);
    exp_err = ohs && ((sop_f != (mdl_k == 0)) || (eop_f != (mdl_k == NP-1)));
    if (mdl_idle) begin
      mdl_sel = s_req; mdl_idle = 0;
    end else if (!mdl_live) begin
      if (go) begin mdl_live = 1; mdl_k = 0; end
    end else if (ohs) begin
      if (mdl_k == NP-1) begin
        mdl_k = 0;
        if (s_req != mdl_sel) begin mdl_sel = s_req; mdl_live = 0; end
      end else mdl_k++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 0; src_valid = '0; out_ready = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_active_sel", active_sel, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_len", err_len, 0);
    mdl_sel = 0; mdl_live = 0; mdl_idle = 1; mdl_k = 0; exp_fd = 0; exp_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic run_frames(input int nfd, input string tag);
    int got = 0;
    for (int n = 0; n < 3000 && got < nfd; n++) begin
      cycle();
      if (fd_seen) got++;
    end
    chk({tag, "_frames"}, got, nfd);
  endtask

  initial begin
    int got;
    reset = 1; sel_req = 2'd1; out_ready = 0;
    src_valid = '0; src_sop = '0; src_eop = '0; src_data = '0;
    for (int i = 0; i < NS; i++) begin fid[i] = 0; bad[i] = -1; end
    pos[0] = 0; pos[1] = 11; pos[2] = 3;
    @(negedge clk);

    // 1: src1 starts mid-frame, five beats flushed before its sop
    do_reset();
    cnt_drop1 = 0; cnt_out = 0;
    run_frames(1, "t1");
    chk("t1_drops", cnt_drop1, 5);
    chk("t1_beats", out_at_fd, 16);

    // 2: request src2 part-way through a src0 frame
    sel_req = 2'd0;
    do_reset();
    got = 0;
    for (int n = 0; n < 3000 && got < 2; n++) begin
      if (mdl_live && mdl_sel == 0 && mdl_k == 7) sel_req = 2'd2;
      cycle();
      if (fd_seen) got++;
    end
    chk("t2_frames", got, 2);
    chk("t2_active", active_sel, 2);

    // 3: random backpressure and source bubbles
    p_valid = 70; p_rdy = 50;
    run_frames(3, "t3");

    // 4: src0 flags eop early at position 10
    sel_req = 2'd0; bad[0] = 10; p_valid = 100; p_rdy = 70;
    do_reset();
    cnt_err = 0; cnt_out = 0;
    run_frames(1, "t4");
    chk("t4_err_pulses", cnt_err, 1);
    chk("t4_beats", out_at_fd, 16);
    bad[0] = -1;

    // 5: out-of-range request clamps; reset mid-frame restarts cleanly
    sel_req = 2'd3; p_valid = 80; p_rdy = 80;
    do_reset();
    cycle();
    chk("t5_clamp", active_sel, 0);
    got = 0;
    for (int n = 0; n < 500 && !(mdl_live && mdl_k == 9); n++) cycle();
    chk("t5_reach_beat9", mdl_live && mdl_k == 9, 1);
    do_reset();
    cnt_out = 0;
    run_frames(1, "t5");
    chk("t5_beats", out_at_fd, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
